// File: rtl/mem_arbiter_if.sv
// Bundle of the cache-side request/response signals and the RAM-side port
// seen by the memory arbiter. slave is the arbiter view, master the environment view.
interface mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic              iREN;
   logic [ADDR_W-1:0] iaddr;
   logic              dREN;
   logic              dWEN;
   logic [ADDR_W-1:0] daddr;
   logic [DATA_W-1:0] dstore;
   logic [1:0]        ramstate;
   logic [DATA_W-1:0] ramload;
   logic              iwait;
   logic              dwait;
   logic [DATA_W-1:0] iload;
   logic [DATA_W-1:0] dload;
   logic              ramREN;
   logic              ramWEN;
   logic [ADDR_W-1:0] ramaddr;
   logic [DATA_W-1:0] ramstore;
   logic [1:0]        gnt;

   modport slave (
      input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
      output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, gnt
   );

   modport master (
      output iREN, iaddr, dREN, dWEN, daddr, dstore, ramstate, ramload,
      input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore, gnt
   );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one RAM port between icache and dcache: dcache grants are held for a
// whole block burst, and a starving icache eventually overrides dcache priority.
module mem_arbiter #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int BURST      = 2,
   parameter int STARVE_MAX = 8
) (
   input logic          CLK,
   input logic          RST,
   mem_arbiter_if.slave bus
);
   localparam int WCNT_W = (BURST > 1) ? $clog2(BURST) : 1;
   localparam int STRV_W = $clog2(STARVE_MAX + 1);
   localparam logic [1:0]        RAM_ACCESS = 2'd2;
   localparam logic [WCNT_W-1:0] LAST_WORD  = WCNT_W'(BURST - 1);
   localparam logic [STRV_W-1:0] STRV_LIMIT = STRV_W'(STARVE_MAX);

   // Encoding matches the gnt owner code so gnt is the state itself.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      IGNT = 2'd1,
      DGNT = 2'd2
   } state_t;

   state_t            state_q,   state_d;
   logic [WCNT_W-1:0] wordCnt_q, wordCnt_d;
   logic [STRV_W-1:0] starve_q,  starve_d;

   logic access;
   logic dReq;

   assign access    = (bus.ramstate == RAM_ACCESS);
   assign dReq      = bus.dREN | bus.dWEN;
   assign bus.iload = bus.ramload;
   assign bus.dload = bus.ramload;
   assign bus.gnt   = state_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q   <= IDLE;
         wordCnt_q <= '0;
         starve_q  <= '0;
      end else begin
         state_q   <= state_d;
         wordCnt_q <= wordCnt_d;
         starve_q  <= starve_d;
      end
   end

   always_comb begin
      state_d      = state_q;
      wordCnt_d    = wordCnt_q;
      starve_d     = starve_q;
      bus.ramREN   = 1'b0;
      bus.ramWEN   = 1'b0;
      bus.ramaddr  = '0;
      bus.ramstore = '0;
      bus.iwait    = 1'b1;
      bus.dwait    = 1'b1;

      unique case (state_q)
         IDLE: begin
            if (bus.iREN && (starve_q >= STRV_LIMIT)) begin
               state_d = IGNT;
            end else if (dReq) begin
               state_d = DGNT;
            end else if (bus.iREN) begin
               state_d = IGNT;
            end
         end

         DGNT: begin
            bus.ramaddr  = bus.daddr;
            bus.ramstore = bus.dstore;
            bus.ramWEN   = bus.dWEN;
            bus.ramREN   = bus.dREN & ~bus.dWEN;
            bus.dwait    = ~access;
            // The grant survives read/write switches; only the word count or a dropped request ends it.
            if (!dReq) begin
               state_d   = IDLE;
               wordCnt_d = '0;
            end else if (access) begin
               if (wordCnt_q == LAST_WORD) begin
                  state_d   = IDLE;
                  wordCnt_d = '0;
               end else begin
                  wordCnt_d = wordCnt_q + WCNT_W'(1);
               end
            end
         end

         IGNT: begin
            bus.ramaddr = bus.iaddr;
            bus.ramREN  = bus.iREN;
            bus.iwait   = ~access;
            if (!bus.iREN || access) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase

      if ((state_d == IGNT) && (state_q != IGNT)) begin
         starve_d = '0;
      end else if (bus.iREN && (state_q != IGNT) && (starve_q < STRV_LIMIT)) begin
         starve_d = starve_q + STRV_W'(1);
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios with per-cycle
// expectations plus a randomized run, all against a transaction-level model.
module tb_mem_arbiter;
   localparam int ADDR_W     = 32;
   localparam int DATA_W     = 32;
   localparam int BURST      = 2;
   localparam int STARVE_MAX = 8;
   localparam int OUT_W      = 2 + 4 + ADDR_W * 2 + DATA_W * 2;

   localparam int FREE   = 0;
   localparam int BUSY   = 1;
   localparam int ACCESS = 2;
   localparam int ERROR  = 3;

   logic CLK;
   logic RST;
   int   vecCount;
   int   missCount;

   // Model: who owns the port, words finished in the current dcache block,
   // and how many cycles the icache has been kept waiting.
   int modelOwner;
   int modelWords;
   int modelStarve;

   mem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

   mem_arbiter #(
      .ADDR_W    (ADDR_W),
      .DATA_W    (DATA_W),
      .BURST     (BURST),
      .STARVE_MAX(STARVE_MAX)
   ) dut (
      .CLK(CLK),
      .RST(RST),
      .bus(bus)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   function automatic logic [OUT_W-1:0] outVec();
      return {bus.gnt, bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait,
              bus.ramaddr, bus.ramstore, bus.iload, bus.dload};
   endfunction

   function automatic logic [OUT_W-1:0] modelVec();
      logic ren, wen, iw, dw;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] s;
      bit acc;
      acc = (bus.ramstate == 2'(ACCESS));
      ren = 1'b0; wen = 1'b0; iw = 1'b1; dw = 1'b1; a = '0; s = '0;
      if (modelOwner == 2) begin
         a   = bus.daddr;
         s   = bus.dstore;
         wen = bus.dWEN;
         ren = bus.dREN && !bus.dWEN;
         dw  = !acc;
      end else if (modelOwner == 1) begin
         a   = bus.iaddr;
         ren = bus.iREN;
         iw  = !acc;
      end
      return {2'(modelOwner), ren, wen, iw, dw, a, s, bus.ramload, bus.ramload};
   endfunction

   function automatic void modelStep();
      int  nextOwner;
      bit  acc;
      bit  dReq;
      acc  = (bus.ramstate == 2'(ACCESS));
      dReq = bus.dREN || bus.dWEN;
      nextOwner = modelOwner;
      if (modelOwner == 0) begin
         if (bus.iREN && modelStarve >= STARVE_MAX) nextOwner = 1;
         else if (dReq)                            nextOwner = 2;
         else if (bus.iREN)                        nextOwner = 1;
      end else if (modelOwner == 2) begin
         if (!dReq) begin
            nextOwner  = 0;
            modelWords = 0;
         end else if (acc) begin
            modelWords = modelWords + 1;
            if (modelWords == BURST) begin
               nextOwner  = 0;
               modelWords = 0;
            end
         end
      end else begin
         if (!bus.iREN || acc) nextOwner = 0;
      end
      if (modelOwner != 1 && nextOwner == 1) modelStarve = 0;
      else if (bus.iREN && modelOwner != 1)  modelStarve = (modelStarve + 1 > STARVE_MAX) ? STARVE_MAX : modelStarve + 1;
      modelOwner = nextOwner;
   endfunction

   function automatic void modelReset();
      modelOwner  = 0;
      modelWords  = 0;
      modelStarve = 0;
   endfunction

   task automatic applyStimulus(input bit i, input bit d, input bit w, input int rs);
      bus.iREN     = i;
      bus.dREN     = d;
      bus.dWEN     = w;
      bus.ramstate = 2'(rs);
      bus.iaddr    = $urandom;
      bus.daddr    = $urandom;
      bus.dstore   = $urandom;
      bus.ramload  = $urandom;
   endtask

   task automatic advance();
      @(posedge CLK);
      modelStep();
      @(negedge CLK);
   endtask

   task automatic doReset();
      applyStimulus(0, 0, 0, FREE);
      RST = 1'b1;
      modelReset();
      @(negedge CLK);
      @(negedge CLK);
      RST = 1'b0;
   endtask

   task automatic test_reset();
      doReset();
      #1;
      vecCount++;
      if (outVec() !== modelVec()) begin
         missCount++;
         $display("FAIL reset_idle got=%h want=%h", outVec(), modelVec());
      end
      vecCount++;
      if ({bus.gnt, bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN} !== 6'b00_11_00) begin
         missCount++;
         $display("FAIL reset_values got=%b want=001100", {bus.gnt, bus.iwait, bus.dwait, bus.ramREN, bus.ramWEN});
      end
      @(negedge CLK);
      applyStimulus(0, 1, 1, ACCESS);
      advance();
      applyStimulus(0, 1, 1, ACCESS);
      #1;
      vecCount++;
      if ({bus.gnt, bus.ramWEN} !== 3'b10_1) begin
         missCount++;
         $display("FAIL reset_pre_dgnt got=%b want=101", {bus.gnt, bus.ramWEN});
      end
      RST = 1'b1;
      modelReset();
      #1;
      vecCount++;
      if ({bus.gnt, bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ramaddr} !== {2'd0, 4'b0011, 32'd0}) begin
         missCount++;
         $display("FAIL reset_mid_dgnt got=%h want=%h",
                  {bus.gnt, bus.ramREN, bus.ramWEN, bus.iwait, bus.dwait, bus.ramaddr}, {2'd0, 4'b0011, 32'd0});
      end
      @(negedge CLK);
      RST = 1'b0;
      for (int c = 0; c < 3; c++) begin
         applyStimulus(0, 0, 0, ACCESS);
         #1;
         vecCount++;
         if (bus.gnt !== 2'd0) begin
            missCount++;
            $display("FAIL reset_release_idle cycle=%0d got=%0d want=0", c, bus.gnt);
         end
         advance();
      end
   endtask

   task automatic test_simultaneous();
      int iR[12] = '{1,1,1,1,1,1,1,1,1,1,1,0};
      int dR[12] = '{1,1,1,1,1,1,1,0,0,0,0,0};
      int rs[12] = '{FREE,BUSY,BUSY,ACCESS,BUSY,BUSY,ACCESS,FREE,BUSY,BUSY,ACCESS,FREE};
      int gE[12] = '{0,2,2,2,2,2,2,0,1,1,1,0};
      int dW[12] = '{1,1,1,0,1,1,0,1,1,1,1,1};
      int iW[12] = '{1,1,1,1,1,1,1,1,1,1,0,1};
      doReset();
      for (int c = 0; c < 12; c++) begin
         applyStimulus(iR[c] != 0, dR[c] != 0, 0, rs[c]);
         #1;
         vecCount++;
         if (outVec() !== modelVec()) begin
            missCount++;
            $display("FAIL simultaneous_model cycle=%0d got=%h want=%h", c, outVec(), modelVec());
         end
         vecCount++;
         if ({bus.gnt, bus.dwait, bus.iwait} !== {2'(gE[c]), 1'(dW[c]), 1'(iW[c])}) begin
            missCount++;
            $display("FAIL simultaneous_seq cycle=%0d got=%b want=%b", c,
                     {bus.gnt, bus.dwait, bus.iwait}, {2'(gE[c]), 1'(dW[c]), 1'(iW[c])});
         end
         advance();
      end
   endtask

   task automatic test_burst_lock();
      int wW[8] = '{1,1,1,0,0,0,0,0};
      int dR[8] = '{0,0,0,1,1,1,0,0};
      int gE[8] = '{0,2,2,0,2,2,0,1};
      int weE[8] = '{0,1,1,0,0,0,0,0};
      int reE[8] = '{0,0,0,0,1,1,0,1};
      doReset();
      for (int c = 0; c < 8; c++) begin
         applyStimulus(1, dR[c] != 0, wW[c] != 0, ACCESS);
         #1;
         vecCount++;
         if (outVec() !== modelVec()) begin
            missCount++;
            $display("FAIL burst_lock_model cycle=%0d got=%h want=%h", c, outVec(), modelVec());
         end
         vecCount++;
         if ({bus.gnt, bus.ramWEN, bus.ramREN} !== {2'(gE[c]), 1'(weE[c]), 1'(reE[c])}) begin
            missCount++;
            $display("FAIL burst_lock_seq cycle=%0d got=%b want=%b", c,
                     {bus.gnt, bus.ramWEN, bus.ramREN}, {2'(gE[c]), 1'(weE[c]), 1'(reE[c])});
         end
         advance();
      end
   endtask

   task automatic test_starvation();
      int gE[13] = '{0,2,2,0,2,2,0,2,2,0,1,0,2};
      doReset();
      for (int c = 0; c < 13; c++) begin
         applyStimulus(1, 1, 0, ACCESS);
         #1;
         vecCount++;
         if (outVec() !== modelVec()) begin
            missCount++;
            $display("FAIL starvation_model cycle=%0d got=%h want=%h", c, outVec(), modelVec());
         end
         vecCount++;
         if (bus.gnt !== 2'(gE[c])) begin
            missCount++;
            $display("FAIL starvation_gnt cycle=%0d got=%0d want=%0d", c, bus.gnt, gE[c]);
         end
         advance();
      end
   endtask

   task automatic test_early_release();
      int dR[7] = '{1,1,0,1,1,1,0};
      int rs[7] = '{FREE,ACCESS,FREE,FREE,ACCESS,ACCESS,FREE};
      int gE[7] = '{0,2,2,0,2,2,0};
      int reE[7] = '{0,1,0,0,1,1,0};
      doReset();
      for (int c = 0; c < 7; c++) begin
         applyStimulus(0, dR[c] != 0, 0, rs[c]);
         #1;
         vecCount++;
         if (outVec() !== modelVec()) begin
            missCount++;
            $display("FAIL early_release_model cycle=%0d got=%h want=%h", c, outVec(), modelVec());
         end
         vecCount++;
         if ({bus.gnt, bus.ramREN} !== {2'(gE[c]), 1'(reE[c])}) begin
            missCount++;
            $display("FAIL early_release_seq cycle=%0d got=%b want=%b", c,
                     {bus.gnt, bus.ramREN}, {2'(gE[c]), 1'(reE[c])});
         end
         advance();
      end
   endtask

   task automatic test_error_hold();
      int iR[8] = '{1,1,1,1,1,1,1,0};
      int rs[8] = '{FREE,ERROR,ERROR,ERROR,ERROR,ERROR,ACCESS,FREE};
      int gE[8] = '{0,1,1,1,1,1,1,0};
      int iW[8] = '{1,1,1,1,1,1,0,1};
      doReset();
      for (int c = 0; c < 8; c++) begin
         applyStimulus(iR[c] != 0, 0, 0, rs[c]);
         #1;
         vecCount++;
         if (outVec() !== modelVec()) begin
            missCount++;
            $display("FAIL error_hold_model cycle=%0d got=%h want=%h", c, outVec(), modelVec());
         end
         vecCount++;
         if ({bus.gnt, bus.iwait} !== {2'(gE[c]), 1'(iW[c])}) begin
            missCount++;
            $display("FAIL error_hold_seq cycle=%0d got=%b want=%b", c,
                     {bus.gnt, bus.iwait}, {2'(gE[c]), 1'(iW[c])});
         end
         advance();
      end
   endtask

   task automatic test_random();
      doReset();
      for (int c = 0; c < 400; c++) begin
         applyStimulus($urandom_range(3, 0) != 0,
                       $urandom_range(2, 0) == 0,
                       $urandom_range(3, 0) == 0,
                       ($urandom_range(1, 0) == 0) ? ACCESS : int'($urandom_range(3, 0)));
         #1;
         vecCount++;
         if (outVec() !== modelVec()) begin
            missCount++;
            $display("FAIL random_model cycle=%0d got=%h want=%h", c, outVec(), modelVec());
         end
         advance();
      end
   endtask

   // Scenarios run back to back, each starting from a fresh reset.
   initial begin
      vecCount  = 0;
      missCount = 0;
      RST       = 1'b1;
      modelReset();
      applyStimulus(0, 0, 0, FREE);
      @(negedge CLK);
      test_reset();
      test_simultaneous();
      test_burst_lock();
      test_starvation();
      test_early_release();
      test_error_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Arbitrates the single shared RAM port between the instruction cache and the data cache.
- Grants the port to one requester at a time.
- Holds a data-cache grant for a full block burst (two-word write-back or fill) so instruction fetches never interleave inside a block.
- Enforces bounded instruction-fetch starvation. Sits between the cache controllers and the RAM model.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data word width
BURST, 2, words per data-cache block transfer (≥1)
STARVE_MAX, 8, cycles icache may wait before it gains priority (≥1)

Ports:
CLK  in  1  clock, rising edge
RST  in  1  asynchronous active-high reset
iREN  in  1  icache read request
iaddr  in  ADDR_W  icache address
dREN  in  1  dcache read request
dWEN  in  1  dcache write request
daddr  in  ADDR_W  dcache address
dstore  in  DATA_W  dcache write data
ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
ramload  in  DATA_W  RAM read data
iwait  out  1  icache stall
dwait  out  1  dcache stall
iload  out  DATA_W  icache read data
dload  out  DATA_W  dcache read data
ramREN  out  1  RAM read strobe
ramWEN  out  1  RAM write strobe
ramaddr  out  ADDR_W  RAM address
ramstore  out  DATA_W  RAM write data
gnt  out  2  current owner: 0 none, 1 icache, 2 dcache

Behaviour:
- Clock and reset: one clock CLK. RST is asynchronous, active-high. While RST=1: state IDLE, word counter 0, starve counter 0.
- Reset output values: ramREN=0, ramWEN=0, ramaddr=0, ramstore=0, iwait=1, dwait=1, gnt=0. Reset mid-transfer abandons the transfer; no further RAM strobes are issued.
- States: IDLE, IGNT, DGNT, held in a registered state register. gnt decodes the state.
- IDLE:
  - Drives no RAM strobes; iwait=dwait=1.
  - Next state, in priority order:
    - iREN and starve≥STARVE_MAX → IGNT
    - else dREN|dWEN → DGNT
    - else iREN → IGNT
    - else IDLE
  - Arbitration latency is one cycle: a request seen in IDLE is driven to RAM in the following cycle.
- DGNT:
  - ramaddr=daddr, ramstore=dstore.
  - ramWEN=dWEN. ramREN=dREN&~dWEN; write wins if both are asserted.
  - dwait = ~(ramstate==ACCESS); iwait=1.
  - Word counter increments on each ACCESS cycle.
  - Exit to IDLE when ACCESS occurs with counter==BURST-1 (counter clears), or when dREN|dWEN==0 (counter clears). Otherwise stay.
  - A switch from write to read inside the burst stays in the same grant and counts toward BURST.
- IGNT:
  - ramaddr=iaddr, ramREN=iREN, ramWEN=0, ramstore=0.
  - iwait = ~(ramstate==ACCESS); dwait=1.
  - Exit to IDLE on ACCESS (single word) or when iREN drops.
- Data return: iload=ramload and dload=ramload at all times. They are valid only when the matching wait is low.
- ERROR and BUSY: treated as not-ACCESS. Grant held, waits stay high, counters unchanged.
- Starve counter:
  - Width clog2(STARVE_MAX+1), saturating at STARVE_MAX.
  - Increments each cycle iREN=1 and state≠IGNT.
  - Clears on entry to IGNT.
- Simultaneous events:
  - iREN and dREN arriving together with starve<STARVE_MAX → dcache wins.
  - A request dropping in the same cycle as ACCESS → exit to IDLE; the access completes normally.
- Word counter width: clog2(BURST), with a minimum of 1 bit. It never exceeds BURST-1.

Test Plan:
- Reset: assert RST mid-DGNT with ramstate=ACCESS → same cycle ramREN=ramWEN=0, iwait=dwait=1, gnt=0. After release with no requests, gnt stays 0.
- Simultaneous: iREN=1, dREN=1, starve=0, RAM returns ACCESS after 2 BUSY cycles →
  - gnt=2 for the full 2-word burst; dwait pulses low twice.
  - Then IDLE for one cycle, then gnt=1, one icache word.
- Burst lock: dWEN for 2 words, then dREN for 2 words, iREN held throughout; ramstate ACCESS every cycle → two DGNT bursts separated by IDLE. Icache is not granted between the bursts (starve<8), then granted after.
- Starvation: dcache requests back-to-back with iREN=1 for ≥8 cycles → once starve=8, the next IDLE grants IGNT even with dREN=1. Starve counter reads 0 after grant.
- Early release: dREN drops after 1 ACCESS of a BURST=2 transfer → next cycle IDLE, counter=0, no extra ramREN.
- ERROR hold: ramstate=3 for 5 cycles in IGNT → iwait=1, gnt=1 throughout. ACCESS on cycle 6 → iwait=0, iload=ramload, next cycle IDLE.
